// File: rtl/clefia_f0f1_xor_pipe.sv
// clefia_f0f1_xor_pipe
// F0/F1 output combiner for the CLEFIA round. It XORs the register-file word
// with the F-function output and muxes either that result or the
// pass-through word back to the round datapath. The XOR result also feeds a
// DEPTH-stage delay line. The delay line has per-stage valid tags, stall and
// flush controls, a run-time output tap, and an occupancy counter.
//
// Input handshake: a word is accepted into stage 0 only in a cycle with
// in_valid=1, stall=0, flush=0 and rst=0. There is no ready output. While
// stall or flush is high the upstream block must hold its word, because any
// in_valid seen in those cycles is dropped.
// Priority at each clock edge: rst > flush > stall > advance.
module clefia_f0f1_xor_pipe #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 2,
    localparam int TAPW  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNTW  = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_sel,
    input  logic [WIDTH-1:0] in_r,
    input  logic [WIDTH-1:0] in_f,
    input  logic [WIDTH-1:0] in_pd,
    input  logic             stall,
    input  logic             flush,
    input  logic [TAPW-1:0]  tap_sel,
    output logic [WIDTH-1:0] out_x,
    output logic [WIDTH-1:0] out_f,
    output logic [WIDTH-1:0] dly_data,
    output logic             dly_valid,
    output logic [CNTW-1:0]  fill_cnt
);

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] vld_d;
    logic [CNTW-1:0]  cnt_q;
    logic [CNTW-1:0]  cnt_d;

    // Combinational XOR and round-datapath mux; independent of all controls.
    always_comb begin
        out_x = in_r ^ in_f;
        out_f = in_sel ? out_x : in_pd;
    end

    // Next state of the delay line. Data follows stall only; the valid tags
    // and the count additionally obey flush.
    always_comb begin
        stage_d = stage_q;
        vld_d   = vld_q;
        cnt_d   = cnt_q;
        if (!stall) begin
            stage_d[0] = out_x;
            for (int i = 1; i < DEPTH; i++) begin
                stage_d[i] = stage_q[i-1];
            end
        end
        if (flush) begin
            vld_d = '0;
            cnt_d = '0;
        end else if (!stall) begin
            vld_d[0] = in_valid;
            for (int i = 1; i < DEPTH; i++) begin
                vld_d[i] = vld_q[i-1];
            end
            // Entering tag adds one, tag leaving the last stage removes one.
            cnt_d = cnt_q + CNTW'(in_valid) - CNTW'(vld_q[DEPTH-1]);
        end
    end

    // State registers with synchronous reset that clears data as well.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
            vld_q <= '0;
            cnt_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= stage_d[i];
            end
            vld_q <= vld_d;
            cnt_q <= cnt_d;
        end
    end

    // Output tap. A tap that names no stage reads as zero and invalid.
    always_comb begin
        dly_data  = '0;
        dly_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (tap_sel == TAPW'(i)) begin
                dly_data  = stage_q[i];
                dly_valid = vld_q[i];
            end
        end
    end

    assign fill_cnt = cnt_q;

endmodule

// File: tb/tb_clefia_f0f1_xor_pipe.sv
// Directed bench for clefia_f0f1_xor_pipe. It runs three instances
// (DEPTH 2, 3 and 4) that share their data and control inputs. Each instance
// has its own tap select.
module tb_clefia_f0f1_xor_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_sel;
    logic [31:0] in_r;
    logic [31:0] in_f;
    logic [31:0] in_pd;
    logic        stall;
    logic        flush;

    logic        tap2;
    logic [1:0]  tap3;
    logic [1:0]  tap4;

    logic [31:0] out_x2, out_f2, dd2;
    logic [31:0] out_x3, out_f3, dd3;
    logic [31:0] out_x4, out_f4, dd4;
    logic        dv2, dv3, dv4;
    logic [1:0]  fc2;
    logic [1:0]  fc3;
    logic [2:0]  fc4;

    int errors = 0;
    int checks = 0;

    localparam logic [31:0] W0 = 32'h1111_0000;
    localparam logic [31:0] W1 = 32'h2222_0000;
    localparam logic [31:0] W2 = 32'h3333_0000;
    localparam logic [31:0] W9 = 32'h9999_9999;

    clefia_f0f1_xor_pipe #(.WIDTH(32), .DEPTH(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sel(in_sel),
        .in_r(in_r), .in_f(in_f), .in_pd(in_pd), .stall(stall), .flush(flush),
        .tap_sel(tap2), .out_x(out_x2), .out_f(out_f2), .dly_data(dd2),
        .dly_valid(dv2), .fill_cnt(fc2)
    );

    clefia_f0f1_xor_pipe #(.WIDTH(32), .DEPTH(3)) dut3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sel(in_sel),
        .in_r(in_r), .in_f(in_f), .in_pd(in_pd), .stall(stall), .flush(flush),
        .tap_sel(tap3), .out_x(out_x3), .out_f(out_f3), .dly_data(dd3),
        .dly_valid(dv3), .fill_cnt(fc3)
    );

    clefia_f0f1_xor_pipe #(.WIDTH(32), .DEPTH(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sel(in_sel),
        .in_r(in_r), .in_f(in_f), .in_pd(in_pd), .stall(stall), .flush(flush),
        .tap_sel(tap4), .out_x(out_x4), .out_f(out_f4), .dly_data(dd4),
        .dly_valid(dv4), .fill_cnt(fc4)
    );

    // Clock generation.
    always #5 clk = ~clk;

    // One comparison: count it, and on mismatch count and report the failure.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge; the inputs change and are sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a word that is one of the bench constants: in_r carries it and in_f is 0.
    task automatic put(input logic v, input logic [31:0] w);
        in_valid = v;
        in_r     = w;
        in_f     = 32'h0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_sel = 1'b0;
        in_r = '0; in_f = '0; in_pd = '0;
        stall = 1'b0; flush = 1'b0;
        tap2 = 1'b1; tap3 = 2'd0; tap4 = 2'd0;

        // Reset and combinational path.
        tick(); tick();
        rst = 1'b0;
        in_r = 32'hA5A5_0000; in_f = 32'h0F0F_FFFF; in_sel = 1'b1;
        #1;
        check("comb_out_x", out_x2, 32'hAAAA_FFFF);
        check("comb_out_f_xor", out_f2, 32'hAAAA_FFFF);
        check("rst_dly_valid", {31'b0, dv2}, 32'd0);
        check("rst_dly_data", dd2, 32'd0);
        check("rst_fill_cnt", {30'b0, fc2}, 32'd0);
        check("rst_fill_cnt_d4", {29'b0, fc4}, 32'd0);
        in_sel = 1'b0; in_pd = 32'h1234_5678;
        #1;
        check("comb_out_f_pd", out_f2, 32'h1234_5678);

        // Legacy timing: DEPTH=2, tap 1. X0=12345678 X1=F00FF00F X2=CAFEBABE.
        in_valid = 1'b1; in_r = 32'h1234_0000; in_f = 32'h0000_5678;
        tick();
        check("leg_e1_valid", {31'b0, dv2}, 32'd0);
        check("leg_e1_fill", {30'b0, fc2}, 32'd1);
        in_r = 32'hFF00_FF00; in_f = 32'h0F0F_0F0F;
        tick();
        check("leg_e2_data", dd2, 32'h1234_5678);
        check("leg_e2_valid", {31'b0, dv2}, 32'd1);
        check("leg_e2_fill", {30'b0, fc2}, 32'd2);
        in_r = 32'hCAFE_0000; in_f = 32'h0000_BABE;
        tick();
        check("leg_e3_data", dd2, 32'hF00F_F00F);
        check("leg_e3_fill", {30'b0, fc2}, 32'd2);
        put(1'b1, 32'h0F0F_F0F0);
        tick();
        check("leg_e4_data", dd2, 32'hCAFE_BABE);
        check("leg_e4_valid", {31'b0, dv2}, 32'd1);
        check("leg_e4_fill", {30'b0, fc2}, 32'd2);
        put(1'b0, 32'h0);
        tick();
        check("leg_e5_data", dd2, 32'h0F0F_F0F0);
        check("leg_e5_fill", {30'b0, fc2}, 32'd1);

        // Tap sweep on DEPTH=4 after a flush.
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_fill_d4", {29'b0, fc4}, 32'd0);
        in_valid = 1'b1; in_r = 32'hDEAD_0000; in_f = 32'h0000_BEEF;
        for (int n = 1; n <= 5; n++) begin
            tick();
            put(1'b0, 32'h0);
            for (int k = 0; k < 4; k++) begin
                tap4 = k[1:0];
                #1;
                check($sformatf("sweep_e%0d_t%0d_valid", n, k), {31'b0, dv4},
                      (n == k + 1) ? 32'd1 : 32'd0);
                if (n == k + 1)
                    check($sformatf("sweep_e%0d_t%0d_data", n, k), dd4, 32'hDEAD_BEEF);
            end
            check($sformatf("sweep_e%0d_fill", n), {29'b0, fc4}, (n <= 4) ? 32'd1 : 32'd0);
        end

        // Stall on DEPTH=2: load W0 then W1, then stall three cycles with W9 offered.
        flush = 1'b1;
        tick();
        flush = 1'b0;
        put(1'b1, W0); tick();
        put(1'b1, W1); tick();
        stall = 1'b1;
        put(1'b1, W9);
        for (int s = 0; s < 3; s++) begin
            tick();
            tap2 = 1'b1;
            #1;
            check($sformatf("stall%0d_t1_data", s), dd2, W0);
            check($sformatf("stall%0d_t1_valid", s), {31'b0, dv2}, 32'd1);
            tap2 = 1'b0;
            #1;
            check($sformatf("stall%0d_t0_data", s), dd2, W1);
            check($sformatf("stall%0d_fill", s), {30'b0, fc2}, 32'd2);
        end
        stall = 1'b0;
        put(1'b0, 32'h0);
        tick();
        tap2 = 1'b1;
        #1;
        check("unstall_t1_data", dd2, W1);
        check("unstall_t1_valid", {31'b0, dv2}, 32'd1);
        check("unstall_fill", {30'b0, fc2}, 32'd1);
        tap2 = 1'b0;
        #1;
        check("unstall_t0_valid", {31'b0, dv2}, 32'd0);

        // Flush together with stall while a word is offered.
        put(1'b1, W0); tick();
        put(1'b1, W1); tick();
        check("pre_flush_fill", {30'b0, fc2}, 32'd2);
        flush = 1'b1; stall = 1'b1;
        put(1'b1, W9);
        tick();
        flush = 1'b0; stall = 1'b0;
        put(1'b0, 32'h0);
        check("fs_fill", {30'b0, fc2}, 32'd0);
        tap2 = 1'b0; #1;
        check("fs_t0_valid", {31'b0, dv2}, 32'd0);
        tap2 = 1'b1; #1;
        check("fs_t1_valid", {31'b0, dv2}, 32'd0);

        // Reset together with a valid word, flush low.
        put(1'b1, W0); tick();
        put(1'b1, W1); tick();
        check("pre_rst_fill", {30'b0, fc2}, 32'd2);
        rst = 1'b1;
        put(1'b1, W9);
        tick();
        rst = 1'b0;
        put(1'b0, 32'h0);
        check("rst_fill", {30'b0, fc2}, 32'd0);
        check("rst_fill_d4", {29'b0, fc4}, 32'd0);
        tap2 = 1'b0; #1;
        check("rst_t0_valid", {31'b0, dv2}, 32'd0);
        check("rst_t0_data", dd2, 32'd0);
        tap2 = 1'b1; #1;
        check("rst_t1_valid", {31'b0, dv2}, 32'd0);
        check("rst_t1_data", dd2, 32'd0);

        // Out-of-range tap on DEPTH=3 with a full pipe.
        put(1'b1, W0); tick();
        put(1'b1, W1); tick();
        put(1'b1, W2); tick();
        put(1'b0, 32'h0);
        check("oor_fill_d3", {30'b0, fc3}, 32'd3);
        check("oor_fill_d4", {29'b0, fc4}, 32'd3);
        tap3 = 2'd3; #1;
        check("oor_t3_data", dd3, 32'd0);
        check("oor_t3_valid", {31'b0, dv3}, 32'd0);
        tap3 = 2'd2; #1;
        check("oor_t2_data", dd3, W0);
        check("oor_t2_valid", {31'b0, dv3}, 32'd1);
        tap3 = 2'd0; #1;
        check("oor_t0_data", dd3, W2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/clefia_f0f1_xor_pipe.md
Name: clefia_f0f1_xor_pipe

Overview:
- Parametrised successor of the F0F1 in/out datapath in the CLEFIA round.
- XORs the register-file word with the F0/F1 function output.
- Muxes either that result or the pass-through word back to the round datapath, combinationally.
- Feeds the XOR result into a DEPTH-stage delay line with per-stage valid tags, stall and flush controls, a run-time selectable output tap, and an occupancy counter.

Parameters:
- WIDTH, 32, data word width in bits.
- DEPTH, 2, number of delay stages; legal range is 1 or more.
- TAPW, max(1, $clog2(DEPTH)), width of the tap select (derived; do not override).
- CNTW, $clog2(DEPTH+1), width of the occupancy count (derived).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  in_r/in_f carry a valid word this cycle.
- in_sel  input  1  mux select: 0 selects in_pd, 1 selects the XOR result.
- in_r  input  WIDTH  register-file word (R9 role).
- in_f  input  WIDTH  F0/F1 function output.
- in_pd  input  WIDTH  pass-through datapath word.
- stall  input  1  hold the delay line.
- flush  input  1  invalidate the delay line contents.
- tap_sel  input  TAPW  output tap; value k gives k+1 cycles of delay.
- out_x  output  WIDTH  combinational in_r ^ in_f.
- out_f  output  WIDTH  combinational mux result.
- dly_data  output  WIDTH  data at the selected stage.
- dly_valid  output  1  valid tag at the selected stage.
- fill_cnt  output  CNTW  number of valid entries in the delay line.

Behaviour:
- Combinational outputs:
  - out_x = in_r ^ in_f, full WIDTH, with no carry.
  - out_f = in_sel ? out_x : in_pd.
  - Both are unaffected by rst, stall or flush.
- Storage: stage[0..DEPTH-1] of WIDTH bits each, plus vld[0..DEPTH-1].
- Reset (rst=1 at a clock edge):
  - All stage, vld and fill_cnt clear to 0.
  - As a result dly_data=0, dly_valid=0 and fill_cnt=0 from the next cycle.
  - rst has priority over flush and stall.
  - Reset mid-stream discards all in-flight data.
- Flush (rst=0, flush=1):
  - All vld and fill_cnt clear to 0.
  - Stage data regs still shift if stall=0, and hold if stall=1; their contents are don't-care while invalid.
  - The input word in that cycle is NOT captured as valid.
  - flush overrides stall for the valid tags.
- Advance (rst=0, flush=0, stall=0):
  - stage[0] <= out_x and vld[0] <= in_valid.
  - stage[i] <= stage[i-1] and vld[i] <= vld[i-1] for i from 1 to DEPTH-1.
  - The word in stage[DEPTH-1] is discarded.
  - Data shifts regardless of in_valid; vld tags track validity.
- Stall (rst=0, flush=0, stall=1):
  - All stage, vld and fill_cnt hold.
  - in_valid in that cycle is dropped; the upstream block must hold its word.
- Tap select:
  - dly_data = stage[tap_sel] and dly_valid = vld[tap_sel], combinational from the registers.
  - Latency is tap_sel+1 advancing cycles from input to dly_data.
  - If tap_sel >= DEPTH (possible when DEPTH is not a power of 2), dly_data=0 and dly_valid=0.
  - tap_sel may change at any cycle; the output follows in the same cycle.
- fill_cnt, on advance:
  - fill_cnt <= fill_cnt + in_valid - vld[DEPTH-1].
  - It always equals the popcount of vld and stays within 0..DEPTH, so no overflow or underflow is possible.
  - It holds on stall and clears on flush or rst.
- Compatibility: DEPTH=2, tap_sel=1 with stall=0 and flush=0 reproduces the legacy two-register delay (R11 timing) of the XOR result.
- Simultaneous events: the priority order is rst > flush > stall > advance.
- DEPTH=1:
  - TAPW=1 and only tap 0 is legal.
  - fill_cnt is 1 bit wide.

Test Plan:
- Reset and combinational path.
  - Stimulus: assert rst for 2 cycles, then apply in_r=32'hA5A5_0000, in_f=32'h0F0F_FFFF with in_sel=1.
  - Required: out_x=out_f=32'hAAAA_FFFF. After reset dly_valid=0, dly_data=0 and fill_cnt=0. Setting in_sel=0 with in_pd=32'h1234_5678 gives out_f=32'h1234_5678.
- Legacy timing (DEPTH=2, tap_sel=1).
  - Stimulus: a valid stream of XOR results X0,X1,X2 on consecutive cycles.
  - Required: dly_data=X0 with dly_valid=1 exactly 2 edges after X0 is applied, then X1 and X2 in the following cycles. fill_cnt reads 1, 2, 2, 2.
- Tap sweep (DEPTH=4).
  - Stimulus: a single valid word 32'hDEAD_BEEF, followed by invalid inputs.
  - Required: for each tap_sel k, dly_valid is high only at edge k+1 with dly_data=32'hDEAD_BEEF. fill_cnt reads 1 for 4 cycles, then 0.
- Stall.
  - Stimulus: with DEPTH=2 and words W0 then W1 loaded, hold stall=1 for 3 cycles while in_valid=1 with W9.
  - Required: stage contents, dly_data and fill_cnt=2 are frozen during the stall. W9 never appears at any tap. After release, the shifting resumes.
- Flush versus stall versus rst.
  - Stimulus: with fill_cnt=2, assert flush=1 and stall=1 together; in a later test, assert rst=1 and flush=0 together while in_valid=1.
  - Required: the next cycle shows fill_cnt=0 and dly_valid=0 at all taps in both cases, and the input word is not captured.
- Out-of-range tap (DEPTH=3).
  - Stimulus: a full pipe with tap_sel=3.
  - Required: dly_data=0 and dly_valid=0. Setting tap_sel=2 returns the oldest word in the same cycle.
